md_seq: RTL

Multiply/divide sequencer for the MIPS pipeline: owns HI/LO, runs mult/multu/div/divu as fixed-latency multi-cycle operations launched from the E stage, and executes mthi/mtlo. Drives the busy-based stall that the hazard logic ORs into the D-stage stall, and qualifies launches with the exception/interrupt cancel so a flushed instruction never alters HI/LO.

---
 rtl/md_seq_pkg.sv | 37 +++
 rtl/md_seq_alu.sv | 65 ++++++
 rtl/md_seq.sv | 117 +++++++++++
 3 files changed

// File: rtl/md_seq_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package md_seq_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NONE  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // True for the multi-cycle operations that occupy the sequencer.
  function automatic logic is_muldiv(md_op_e op);
    logic r;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/md_seq_alu.sv
// Pure combinational 32x32 multiply / divide producing {hi, lo} and a divide-by-zero flag.
module md_alu
  import md_seq_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output md_res_t     res,
  output logic        div_zero
);

  logic [63:0] sa;
  logic [63:0] sb;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] div_u;
  logic [31:0] div_s;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] sq_mag;
  logic [31:0] sr_mag;

  assign div_zero = (b == 32'd0);

  // Sign-extended operands give the signed product in the low 64 bits.
  assign sa     = {{32{a[31]}}, a};
  assign sb     = {{32{b[31]}}, b};
  assign prod_s = sa * sb;
  assign prod_u = {32'd0, a} * {32'd0, b};

  assign abs_a = a[31] ? (~a + 32'd1) : a;
  assign abs_b = b[31] ? (~b + 32'd1) : b;

  // Divisor forced to 1 on zero so the dividers never see x/0; result is discarded.
  assign div_u  = div_zero ? 32'd1 : b;
  assign div_s  = div_zero ? 32'd1 : abs_b;
  assign uq     = a / div_u;
  assign ur     = a % div_u;
  assign sq_mag = abs_a / div_s;
  assign sr_mag = abs_a % div_s;

  always_comb begin
    res = '0;
    case (op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV: begin
        if (!div_zero) begin
          res.lo = (a[31] ^ b[31]) ? (~sq_mag + 32'd1) : sq_mag;
          res.hi = a[31] ? (~sr_mag + 32'd1) : sr_mag;
        end
      end
      MD_DIVU: begin
        if (!div_zero) begin
          res.lo = uq;
          res.hi = ur;
        end
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/md_seq.sv
// HI/LO owner: launches fixed-latency mult/div from E, executes mthi/mtlo, drives the md stall.
module md_seq
  import md_seq_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  md_op_e      op,
  input  logic        cancel,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  md_res_t            stage_q, stage_d;
  logic               dz_q, dz_d;

  md_res_t            alu_res;
  logic               alu_dz;
  logic               launch_c;
  logic               accept_c;

  md_alu u_alu (
    .op       (op),
    .a        (rs_val),
    .b        (rt_val),
    .res      (alu_res),
    .div_zero (alu_dz)
  );

  assign launch_c = start && !cancel;
  assign accept_c = launch_c && (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    stage_d = stage_q;
    dz_d    = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          case (op)
            MD_MTHI: hi_d = rs_val;
            MD_MTLO: lo_d = rs_val;
            MD_MULT, MD_MULTU: begin
              stage_d = alu_res;
              dz_d    = 1'b0;
              cnt_d   = CNT_W'(MULT_CYCLES - 1);
              state_d = ST_RUN;
            end
            MD_DIV, MD_DIVU: begin
              stage_d = alu_res;
              dz_d    = alu_dz;
              cnt_d   = CNT_W'(DIV_CYCLES - 1);
              state_d = ST_RUN;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // Commit on the last busy edge; a zero divisor leaves HI/LO untouched.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          if (!dz_q) begin
            hi_d = stage_q.hi;
            lo_d = stage_q.lo;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      stage_q <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      stage_q <= stage_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign hi       = hi_q;
  assign lo       = lo_q;
  // Combinational so a dependent md instruction in D is held in the launch cycle itself.
  assign stall_md = md_use_d && (busy || (launch_c && is_muldiv(op)));

endmodule
